iccm_arbiter: RTL
=================

Name: iccm_arbiter

Overview:
Owns the single ICCM port (instr_mem_top) and shares it between two requesters:
- the UART boot programmer (iccm_controller write stream);
- the instruction-fetch read path (tlul_sram_adapter req/addr/rdata/rvalid).

It sequences boot: it holds the core in reset while the image is written, then releases the core and grants fetch reads. It tracks outstanding reads so that no read response is lost or misrouted across a mode change.

Parameters:
- AW, 12, ICCM word-address width.
- DW, 32, data width.
- RELEASE_CYCLES, 16, cycles between the programmer finishing and core reset being released (range 1..255).
- MAX_OUTSTANDING, 2, maximum in-flight fetch reads; matches the adapter's Outstanding setting.

Ports:
- clock  in  1  Single clock.
- reset  in  1  Asynchronous, active-high reset.
- prog_we_i  in  1  Programmer write strobe; one word per cycle when high.
- prog_addr_i  in  AW  Programmer word address.
- prog_wdata_i  in  DW  Programmer write data.
- prog_done_i  in  1  Single-cycle pulse: image complete.
- fetch_req_i  in  1  Fetch read request.
- fetch_addr_i  in  AW  Fetch word address.
- fetch_gnt_o  out  1  Fetch request accepted this cycle.
- fetch_rdata_o  out  DW  Read data returned to fetch.
- fetch_rvalid_o  out  1  Read data valid.
- mem_req_o  out  1  ICCM request.
- mem_we_o  out  1  ICCM write enable.
- mem_addr_o  out  AW  ICCM address.
- mem_wdata_o  out  DW  ICCM write data.
- mem_rdata_i  in  DW  ICCM read data.
- mem_rvalid_i  in  1  ICCM read valid, exactly 1 cycle after a read request.
- core_rst_o  out  1  Active-high reset to the core.
- busy_o  out  1  High whenever state is not RUN.
- words_written_o  out  AW+1  Count of words written since the last entry to PROGRAM; saturating.

Behaviour:
- Reset values: state BOOT_WAIT; core_rst_o=1; busy_o=1; all mem_* and fetch_* outputs 0; counters 0.
- States:
  - BOOT_WAIT:
    - prog_we_i -> PROGRAM; that first write is performed in the same cycle.
    - prog_done_i with no writes -> RELEASE; an empty image is allowed.
  - PROGRAM:
    - Each prog_we_i drives mem_req_o=1, mem_we_o=1, addr, wdata combinationally in the same cycle; words_written_o increments.
    - prog_done_i -> RELEASE.
    - prog_we_i and prog_done_i in the same cycle: perform the write, then go to RELEASE.
  - RELEASE:
    - Release counter loads RELEASE_CYCLES-1 on entry and decrements each cycle; at 0 -> RUN.
    - core_rst_o stays 1 throughout.
    - prog_we_i -> back to PROGRAM, performing the write; the counter is discarded.
  - RUN:
    - core_rst_o=0 and busy_o=0.
    - fetch_gnt_o = fetch_req_i && outstanding<MAX_OUTSTANDING && !prog_we_i.
    - A granted fetch drives mem_req_o=1, mem_we_o=0, mem_addr_o=fetch_addr_i.
    - prog_we_i -> DRAIN. The write wins the port that cycle and is performed; fetch_gnt_o=0.
  - DRAIN:
    - core_rst_o=1; no new fetch grants.
    - Further prog_we_i writes are performed.
    - When outstanding==0 -> PROGRAM; words_written_o resets to 0 (it also resets on BOOT_WAIT->PROGRAM).
- Outstanding counter:
  - +1 on each granted fetch; -1 on each mem_rvalid_i; both in the same cycle leave it unchanged.
  - mem_rvalid_i with outstanding==0 is a protocol error: the counter holds at 0 and the response is dropped (fetch_rvalid_o=0). The bench asserts this never happens.
- fetch_rdata_o/fetch_rvalid_o pass mem_rdata_i/mem_rvalid_i through combinationally while outstanding>0. Pending responses are still delivered in DRAIN.
- At most one mem_req_o per cycle; a write and a read never issue together.
- words_written_o saturates at 2^AW.
- Asserting reset mid-operation returns to BOOT_WAIT at once; in-flight reads are discarded and core_rst_o=1.

Decomposition:
- Shared package iccm_arb_pkg holds:
  - state enum arb_state_e {BOOT_WAIT, PROGRAM, RELEASE, RUN, DRAIN};
  - localparam defaults for AW and DW.
- One natural sub-module: iccm_rd_tracker, the outstanding counter plus response routing, parameterised by MAX_OUTSTANDING.

Test Plan:
1. Boot: after reset, write 4 words (addr 0..3, data 0xA0..0xA3), then pulse prog_done_i -> mem writes observed in the same cycles; words_written_o=4; core_rst_o falls exactly 16 cycles after the done pulse.
2. Fetch throughput: in RUN, hold fetch_req_i with addr 0,1,2 -> gnt on consecutive cycles; fetch_rvalid_o 1 cycle later with data 0xA0, 0xA1, 0xA2; outstanding never exceeds 2.
3. Outstanding limit: set MAX_OUTSTANDING=1 and request every cycle -> gnt at most every other cycle.
4. Reprogram mid-run: 2 reads in flight, then prog_we_i (addr 5, 0x55) -> write issued that cycle; both reads still return; core_rst_o=1; state reaches PROGRAM only after the last rvalid.
5. Simultaneous events: prog_we_i and prog_done_i in the same cycle -> write performed, then RELEASE; a write during RELEASE -> PROGRAM with counter restarted.
6. Reset mid-RUN with 1 read outstanding -> outputs return to reset values; the late mem_rvalid_i produces no fetch_rvalid_o.

Source files
------------

// File: rtl/iccm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iccm_arb_pkg
// Description : Shared types and default widths for the ICCM arbiter slice.
//               arb_state_e is the boot/run sequencing state of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package iccm_arb_pkg;

    localparam int unsigned c_AW_DEFAULT = 12;
    localparam int unsigned c_DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        BOOT_WAIT = 3'd0,
        PROGRAM   = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        DRAIN     = 3'd4
    } arb_state_e;

endpackage : iccm_arb_pkg
`default_nettype wire

// File: rtl/iccm_rd_tracker.sv
`default_nettype none
// ============================================================================
// Module      : iccm_rd_tracker
// Description : Counts in-flight ICCM fetch reads and routes read responses
//               back to the fetch path. A response that arrives while no
//               read is outstanding is dropped and the count stays at zero.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               i_grant           - a fetch read is issued this cycle
//               i_mem_rdata/rvalid- ICCM read response
//               o_can_issue       - another read may be issued this cycle
//               o_idle            - no read outstanding
//               o_fetch_rdata/rvalid - response forwarded to fetch
// Revision    : 1.0 - initial release
// ============================================================================
module iccm_rd_tracker #(
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_grant,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_rvalid,
    output logic          o_can_issue,
    output logic          o_idle,
    output logic [DW-1:0] o_fetch_rdata,
    output logic          o_fetch_rvalid
);

    localparam int unsigned       c_CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CW-1:0]   c_MAX = c_CW'(MAX_OUTSTANDING);

    logic [c_CW-1:0] r_count;
    logic            w_resp;

    // Only a response matching an outstanding read is accepted.
    assign w_resp = i_mem_rvalid && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_grant && !w_resp) begin
            r_count <= r_count + 1'b1;
        end else if (!i_grant && w_resp) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_can_issue    = (r_count < c_MAX);
    assign o_idle         = (r_count == '0);
    assign o_fetch_rvalid = w_resp;
    assign o_fetch_rdata  = w_resp ? i_mem_rdata : '0;

endmodule : iccm_rd_tracker
`default_nettype wire

// File: rtl/iccm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iccm_arbiter
// Description : Owns the single ICCM port and shares it between the UART
//               boot programmer (writes) and instruction fetch (reads).
//               Holds the core in reset while an image is written, releases
//               it RELEASE_CYCLES after the image completes, and drains
//               in-flight reads before a reprogram so no response is lost.
// Ports       : clock, reset              - clock, async active-high reset
//               prog_we/addr/wdata/done_i - programmer write stream
//               fetch_req/addr_i, fetch_gnt/rdata/rvalid_o - fetch read path
//               mem_req/we/addr/wdata_o, mem_rdata/rvalid_i - ICCM port
//               core_rst_o                - core reset (active high)
//               busy_o                    - high unless running
//               words_written_o           - saturating write count
// Revision    : 1.0 - initial release
// ============================================================================
module iccm_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int unsigned AW              = c_AW_DEFAULT,
    parameter int unsigned DW              = c_DW_DEFAULT,
    parameter int unsigned RELEASE_CYCLES  = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [DW-1:0] prog_wdata_i,
    input  logic          prog_done_i,
    input  logic          fetch_req_i,
    input  logic [AW-1:0] fetch_addr_i,
    output logic          fetch_gnt_o,
    output logic [DW-1:0] fetch_rdata_o,
    output logic          fetch_rvalid_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_rvalid_i,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic [AW:0]   words_written_o
);

    localparam logic [7:0] c_REL_LOAD  = 8'(RELEASE_CYCLES - 1);
    localparam logic [AW:0] c_WORDS_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_WORDS_ONE = (AW+1)'(1);

    arb_state_e  r_state;
    logic [7:0]  r_rel_cnt;
    logic [AW:0] r_words;
    logic        r_core_rst;
    logic        r_busy;

    logic        w_can_issue;
    logic        w_idle;
    logic        w_gnt;
    logic [AW:0] w_words_inc;

    assign w_words_inc = (r_words == c_WORDS_MAX) ? r_words : r_words + 1'b1;

    // A programmer write always owns the port; fetch only gets it in RUN.
    assign w_gnt = (r_state == RUN) && fetch_req_i && w_can_issue && !prog_we_i;

    assign fetch_gnt_o = w_gnt;
    assign mem_req_o   = prog_we_i || w_gnt;
    assign mem_we_o    = prog_we_i;
    assign mem_addr_o  = prog_we_i ? prog_addr_i : (w_gnt ? fetch_addr_i : '0);
    assign mem_wdata_o = prog_we_i ? prog_wdata_i : '0;

    assign core_rst_o      = r_core_rst;
    assign busy_o          = r_busy;
    assign words_written_o = r_words;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= BOOT_WAIT;
            r_rel_cnt  <= '0;
            r_words    <= '0;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                BOOT_WAIT: begin
                    if (prog_we_i) begin
                        r_words <= c_WORDS_ONE;
                        if (prog_done_i) begin
                            r_state   <= RELEASE;
                            r_rel_cnt <= c_REL_LOAD;
                        end else begin
                            r_state <= PROGRAM;
                        end
                    end else if (prog_done_i) begin
                        // Empty image: go straight to the release countdown.
                        r_state   <= RELEASE;
                        r_rel_cnt <= c_REL_LOAD;
                    end
                end
                PROGRAM: begin
                    if (prog_we_i) begin
                        r_words <= w_words_inc;
                    end
                    if (prog_done_i) begin
                        r_state   <= RELEASE;
                        r_rel_cnt <= c_REL_LOAD;
                    end
                end
                RELEASE: begin
                    if (prog_we_i) begin
                        // Late write: back to programming, countdown discarded.
                        r_state <= PROGRAM;
                        r_words <= w_words_inc;
                    end else if (r_rel_cnt == '0) begin
                        r_state    <= RUN;
                        r_core_rst <= 1'b0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_rel_cnt <= r_rel_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (prog_we_i) begin
                        r_state    <= DRAIN;
                        r_words    <= w_words_inc;
                        r_core_rst <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Stay until every issued read has returned its data.
                    if (w_idle) begin
                        r_state <= PROGRAM;
                        r_words <= prog_we_i ? c_WORDS_ONE : '0;
                    end else if (prog_we_i) begin
                        r_words <= w_words_inc;
                    end
                end
                default: begin
                    r_state    <= BOOT_WAIT;
                    r_core_rst <= 1'b1;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    iccm_rd_tracker #(
        .DW              (DW),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_rd_tracker (
        .clk            (clock),
        .rst            (reset),
        .i_grant        (w_gnt),
        .i_mem_rdata    (mem_rdata_i),
        .i_mem_rvalid   (mem_rvalid_i),
        .o_can_issue    (w_can_issue),
        .o_idle         (w_idle),
        .o_fetch_rdata  (fetch_rdata_o),
        .o_fetch_rvalid (fetch_rvalid_o)
    );

endmodule : iccm_arbiter
`default_nettype wire
